// File: rtl/sqrt_issue.sv
// sqrt_issue: queues 16-bit operands and issues them one at a time to a square-root core; define SQRT_ISSUE_TIMEOUT_EN for the WAIT watchdog
module sqrt_issue #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_root,
  output logic [8:0]  out_rem,
  output logic [15:0] out_operand,
  output logic        out_err,
  output logic [2:0]  core_mode,
  output logic [15:0] core_data,
  output logic        core_start,
  input  logic [7:0]  core_root,
  input  logic [8:0]  core_rem,
  input  logic        core_finish,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sqrt_issue: unsupported FIFO_DEPTH or TIMEOUT_CYC");
  end
  state_t        state_q, state_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   core_data_q, core_data_d, out_operand_q, out_operand_d;
  logic [7:0]    out_root_q, out_root_d;
  logic [8:0]    out_rem_q, out_rem_d;
  logic          out_valid_q, out_valid_d;
  logic          push, pop, done, fail;
  assign in_ready    = count_q != FULL;
  assign core_mode   = 3'd0;
  assign core_start  = state_q == START;
  assign core_data   = core_data_q;
  assign out_valid   = out_valid_q;
  assign out_root    = out_root_q;
  assign out_rem     = out_rem_q;
  assign out_operand = out_operand_q;
  assign busy        = state_q != IDLE || count_q != '0;
  always_comb begin
    push          = in_valid && in_ready;
    pop           = state_q == IDLE && count_q != '0 && (!out_valid_q || out_ready);
    done          = state_q == WAIT && core_finish;
    state_d       = state_q == IDLE ? (pop ? START : IDLE) :
                    state_q == START ? WAIT : (done || fail) ? IDLE : WAIT;
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    core_data_d   = pop ? mem_q[rd_ptr_q] : core_data_q;
    out_operand_d = pop ? mem_q[rd_ptr_q] : out_operand_q;
    out_root_d    = done ? core_root : fail ? 8'd0 : out_root_q;
    out_rem_d     = done ? core_rem : fail ? 9'd0 : out_rem_q;
    out_valid_d   = (done || fail) ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      core_data_q   <= '0;
      out_operand_q <= '0;
      out_root_q    <= '0;
      out_rem_q     <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      core_data_q   <= core_data_d;
      out_operand_q <= out_operand_d;
      out_root_q    <= out_root_d;
      out_rem_q     <= out_rem_d;
      out_valid_q   <= out_valid_d;
    end
`ifdef SQRT_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          out_err_q, out_err_d;
  assign fail    = state_q == WAIT && !core_finish && tmo_q == TW'(TIMEOUT_CYC - 1);
  assign out_err = out_err_q;
  always_comb begin
    tmo_d     = state_q == WAIT ? tmo_q + 1'b1 : '0;
    out_err_d = done ? 1'b0 : fail ? 1'b1 : out_err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tmo_q     <= '0;
      out_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      out_err_q <= out_err_d;
    end
`else
  assign fail    = 1'b0;
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_sqrt_issue.sv
// tb_sqrt_issue: directed checks of sqrt_issue against a latency-2 square-root core stub
module tb_sqrt_issue;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, mute = 1'b0, stray = 1'b0;
  logic in_ready, out_valid, out_err, core_start, core_finish, busy, fin_q, act_q;
  logic [15:0] in_data = 16'd0, out_operand, core_data, op_q;
  logic [7:0] out_root, core_root;
  logic [8:0] out_rem, core_rem;
  logic [2:0] core_mode;
  int vectors = 0, miscompares = 0, starts = 0, hold_err = 0, cnt_q;
  always #5 clk = ~clk;
  sqrt_issue #(.FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem),
    .out_operand(out_operand), .out_err(out_err), .core_mode(core_mode), .core_data(core_data),
    .core_start(core_start), .core_root(core_root), .core_rem(core_rem),
    .core_finish(core_finish), .busy(busy)
  );
  assign core_finish = fin_q | stray;
  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r = 0;
    for (int b = 7; b >= 0; b--)
      if ((r | (1 << b)) * (r | (1 << b)) <= int'(v)) r = r | (1 << b);
    return 8'(r);
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      act_q <= 1'b0;
      cnt_q <= 0;
      fin_q <= 1'b0;
      op_q <= 16'd0;
      core_root <= 8'd0;
      core_rem <= 9'd0;
    end else begin
      fin_q <= 1'b0;
      if (fin_q && core_data !== op_q) hold_err <= hold_err + 1;
      if (core_start) begin
        act_q <= 1'b1;
        cnt_q <= 2;
        op_q <= core_data;
      end else if (act_q) begin
        if (cnt_q == 1) begin
          act_q <= 1'b0;
          if (!mute) begin
            fin_q <= 1'b1;
            core_root <= isqrt(op_q);
            core_rem <= 9'(int'(op_q) - int'(isqrt(op_q)) * int'(isqrt(op_q)));
          end
        end else cnt_q <= cnt_q - 1;
      end
    end
  always @(posedge clk)
    if (!rst && core_start) starts <= starts + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] v);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic check_result(input string tag, input logic [7:0] r, input logic [8:0] m,
                              input logic [15:0] op, input logic e);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_root"}, 32'(out_root), 32'(r));
    chk({tag, "_rem"}, 32'(out_rem), 32'(m));
    chk({tag, "_operand"}, 32'(out_operand), 32'(op));
    chk({tag, "_err"}, 32'(out_err), 32'(e));
  endtask
  initial begin
    int s0, n;
    logic seen;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_root", 32'(out_root), 32'd0);
    chk("rst_out_rem", 32'(out_rem), 32'd0);
    chk("rst_out_operand", 32'(out_operand), 32'd0);
    chk("rst_core_data", 32'(core_data), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("core_mode", 32'(core_mode), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    s0 = starts;
    push(16'd144);
    check_result("r144", 8'd12, 9'd0, 16'd144, 1'b0);
    chk("r144_one_start", 32'(starts - s0), 32'd1);
    push(16'hFFFF);
    check_result("rffff", 8'd255, 9'd510, 16'hFFFF, 1'b0);
    push(16'd0);
    check_result("r0", 8'd0, 9'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_idle_finish", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'd17;
    chk("bb_ready_17", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 16'd100;
    chk("bb_ready_100", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 16'd1000;
    chk("bb_ready_1000", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 16'd65535;
    chk("bb_ready_65535", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 16'd2;
    chk("bb_ready_2", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = 16'd9;
    chk("bb_stall_9", 32'(in_ready), 32'd0);
    check_result("bb17", 8'd4, 9'd1, 16'd17, 1'b0);
    chk("bb_full_9", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bb_space_9", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_result("bb100", 8'd10, 9'd0, 16'd100, 1'b0);
    check_result("bb1000", 8'd31, 9'd39, 16'd1000, 1'b0);
    check_result("bb65535", 8'd255, 9'd510, 16'd65535, 1'b0);
    check_result("bb2", 8'd1, 9'd1, 16'd2, 1'b0);
    check_result("bb9", 8'd3, 9'd0, 16'd9, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    push(16'd144);
    check_result("hold144", 8'd12, 9'd0, 16'd144, 1'b0);
    s0 = starts;
    push(16'd49);
    repeat (20) @(negedge clk);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_root", 32'(out_root), 32'd12);
    chk("hold_rem", 32'(out_rem), 32'd0);
    chk("hold_operand", 32'(out_operand), 32'd144);
    chk("hold_no_start", 32'(starts - s0), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    check_result("after_hold49", 8'd7, 9'd0, 16'd49, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'd100;
    @(negedge clk);
    in_data = 16'd200;
    @(negedge clk);
    in_data = 16'd300;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_operand", 32'(out_operand), 32'd100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_core_start", 32'(core_start), 32'd0);
    chk("mid_rst_core_data", 32'(core_data), 32'd0);
    chk("mid_rst_operand", 32'(out_operand), 32'd0);
    chk("mid_rst_root", 32'(out_root), 32'd0);
    chk("mid_rst_rem", 32'(out_rem), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    push(16'd49);
    check_result("post_rst49", 8'd7, 9'd0, 16'd49, 1'b0);
`ifdef SQRT_ISSUE_TIMEOUT_EN
    mute = 1'b1;
    push(16'd25);
    n = 0;
    while (!core_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_start", 32'(core_start), 32'd1);
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 40);
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(out_err), 32'd1);
    chk("tmo_root", 32'(out_root), 32'd0);
    chk("tmo_rem", 32'(out_rem), 32'd0);
    chk("tmo_operand", 32'(out_operand), 32'd25);
    mute = 1'b0;
    push(16'd36);
    check_result("post_tmo36", 8'd6, 9'd0, 16'd36, 1'b0);
`endif
    repeat (2) @(negedge clk);
    chk("core_data_hold", 32'(hold_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sqrt_issue.md
SQRT_ISSUE -- requirements
Module: sqrt_issue

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, operand queue depth (power of two, 2..16).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 16, watchdog limit in cycles (used only under REQ-030).
REQ-003 SHALL have clk  input  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-004 SHALL have rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have in_valid  input  1, in_data  input  16 (operand), in_ready  output  1 (operand handshake).
REQ-006 SHALL have out_valid  output  1, out_ready  input  1, out_root  output  8, out_rem  output  9, out_operand  output  16, out_err  output  1 (result handshake).
REQ-007 SHALL have core_mode  output  3, core_data  output  16, core_start  output  1 (drive to the square-root core).
REQ-008 SHALL have core_root  input  8, core_rem  input  9, core_finish  input  1 (returned from the square-root core).
REQ-009 SHALL have busy  output  1, high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-010 SHALL drive core_mode constant 3'd0.
REQ-011 SHALL accept an operand on a clk edge where in_valid and in_ready are both high; in_ready = queue not full, from registered count only (no same-cycle pop bypass).
REQ-012 SHALL keep operands in FIFO order; results SHALL leave in acceptance order.
REQ-013 SHALL implement FSM IDLE -> START -> WAIT -> IDLE.
REQ-014 IDLE: if queue non-empty and output slot free (out_valid=0, or out_valid&out_ready this cycle), pop head into core_data and out_operand shadow, go START.
REQ-015 START: core_start=1 for exactly this one cycle, go WAIT; core_start SHALL be 0 in every other state.
REQ-016 WAIT: on core_finish=1, capture core_root/core_rem into out_root/out_rem, set out_valid=1, out_err=0, go IDLE.
REQ-017 core_data SHALL be held stable from the pop edge through the edge that samples core_finish, and SHALL keep its last value while IDLE.
REQ-018 core_finish SHALL be ignored in IDLE and START.
REQ-019 out_valid SHALL stay high with out_root/out_rem/out_operand/out_err stable until out_valid&out_ready; it then clears unless a new capture occurs the same edge.
REQ-020 Issue-gating per REQ-014 SHALL guarantee a capture never overwrites an unconsumed result.
REQ-021 Operand 0 SHALL be issued normally; the core returns root 0, rem 0.
REQ-022 Latency: core_start high in the cycle after the pop edge; out_valid rises on the edge after core_finish is sampled high.
REQ-023 Simultaneous push and pop on a non-full queue SHALL leave count unchanged with both operands preserved.

Reset
REQ-024 On rst: FSM=IDLE, queue empty, in_ready=1 (after reset release), out_valid=0, out_err=0, out_root=0, out_rem=0, out_operand=0, core_data=0, core_start=0, busy=0.
REQ-025 Reset mid-operation SHALL discard queued and in-flight jobs with no result emitted; the core is reset by the same rst.

Configuration
REQ-030 With macro SQRT_ISSUE_TIMEOUT_EN defined: WAIT counts cycles; if core_finish has not been seen by TIMEOUT_CYC cycles after leaving START, emit out_valid=1, out_err=1, out_root=0, out_rem=0, out_operand=that operand, go IDLE; a later stray core_finish SHALL be ignored per REQ-018.
REQ-031 Without SQRT_ISSUE_TIMEOUT_EN: no counter; WAIT waits indefinitely; out_err tied 0.

Verification
REQ-040 Push 16'd144, out_ready=1 -> one core_start pulse, result root 8'd12, rem 9'd0, operand 16'd144, err 0.
REQ-041 Push 16'hFFFF -> root 8'd255, rem 9'd510; push 16'd0 -> root 0, rem 0.
REQ-042 out_ready=0, push 17,100,1000,65535,2,9 back-to-back -> first five accepted, 9 stalled (in_ready=0); release out_ready -> (4,1),(10,0),(31,39),(255,510),(1,1),(3,0) in order.
REQ-043 Assert rst during WAIT with two operands queued -> all outputs at reset values next cycle, no out_valid after release, next pushed 16'd49 returns root 7, rem 0.
REQ-044 With SQRT_ISSUE_TIMEOUT_EN, core stub never asserts finish, push 16'd25 -> out_valid with out_err=1, root 0, rem 0, operand 25 exactly 16 cycles after WAIT entry.
REQ-045 Hold out_valid with out_ready=0 for 20 cycles -> payload unchanged, core_start not asserted again.
